// File: rtl/coord_bcd_sched_pkg.sv
// Shared types and helpers for the coordinate-to-BCD scheduler.
package coord_bcd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV_X = 2'd1,
    CONV_Y = 2'd2
  } state_t;

  localparam int unsigned DROP_CNT_W = 8;

  // Decimal digits needed for a w-bit unsigned value: ceil(w*log10(2)).
  function automatic int unsigned full_digits(input int unsigned w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/coord_bcd_sched_if.sv
// Sample-in / BCD-out bus between the touch front end and the display path.
interface coord_bcd_sched_if #(
  parameter int unsigned COORD_W    = 16,
  parameter int unsigned BCD_DIGITS = 4
) ();

  logic                                         coord_valid;
  logic [2*COORD_W-1:0]                         coord_data;
  logic [8*BCD_DIGITS-1:0]                      bcd_data;
  logic                                         bcd_valid;
  logic                                         busy;
  logic                                         ovf_x;
  logic                                         ovf_y;
  logic [coord_bcd_sched_pkg::DROP_CNT_W-1:0]   drop_cnt;

  modport master (
    output coord_valid, coord_data,
    input  bcd_data, bcd_valid, busy, ovf_x, ovf_y, drop_cnt
  );

  modport slave (
    input  coord_valid, coord_data,
    output bcd_data, bcd_valid, busy, ovf_x, ovf_y, drop_cnt
  );

endinterface

// File: rtl/bcd_dabble_serial.sv
// Serial double-dabble converter: one shift per clock, COORD_W shifts per value.
module bcd_dabble_serial
  import coord_bcd_sched_pkg::*;
#(
  parameter int unsigned COORD_W     = 16,
  parameter int unsigned FULL_DIGITS = full_digits(COORD_W)
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     start,
  input  logic [COORD_W-1:0]       bin,
  output logic                     done,
  output logic [4*FULL_DIGITS-1:0] bcd
);

  localparam int unsigned BCD_W = 4 * FULL_DIGITS;
  localparam int unsigned CNT_W = $clog2(COORD_W + 1);

  logic [CNT_W-1:0]   cnt;
  logic               running;
  logic [COORD_W-1:0] sh_bin;
  logic [BCD_W-1:0]   sh_bcd;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   nxt_bcd;
  logic [COORD_W-1:0] nxt_bin;

  // Add-3 correction on every digit >= 5, then shift one binary bit into the BCD field.
  always_comb begin
    adj = sh_bcd;
    for (int i = 0; i < int'(FULL_DIGITS); i++) begin
      if (sh_bcd[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = sh_bcd[4*i +: 4] + 4'd3;
      end
    end
    nxt_bcd = {adj[BCD_W-2:0], sh_bin[COORD_W-1]};
    nxt_bin = {sh_bin[COORD_W-2:0], 1'b0};
  end

  // Load on start, shift while running, flag done after the last shift.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt     <= '0;
      running <= 1'b0;
      sh_bin  <= '0;
      sh_bcd  <= '0;
      done    <= 1'b0;
    end else if (start) begin
      cnt     <= CNT_W'(COORD_W);
      running <= 1'b1;
      sh_bin  <= bin;
      sh_bcd  <= '0;
      done    <= 1'b0;
    end else if (running) begin
      sh_bin <= nxt_bin;
      sh_bcd <= nxt_bcd;
      cnt    <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        running <= 1'b0;
        done    <= 1'b1;
      end else begin
        done <= 1'b0;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign bcd = sh_bcd;

endmodule

// File: rtl/coord_bcd_sched.sv
// Shares one serial BCD converter between X and Y, with a latest-wins pending slot.
module coord_bcd_sched
  import coord_bcd_sched_pkg::*;
#(
  parameter int unsigned COORD_W    = 16,
  parameter int unsigned BCD_DIGITS = 4,
  parameter bit          SAT_EN     = 1'b1
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  coord_bcd_sched_if.slave   bus
);

  localparam int unsigned FULL_D = full_digits(COORD_W);
  localparam int unsigned FULL_W = 4 * FULL_D;
  localparam int unsigned OUT_W  = 4 * BCD_DIGITS;
  localparam int unsigned EXT_W  = (FULL_W > OUT_W) ? FULL_W : OUT_W;

  state_t state;
  state_t state_nxt;

  logic                  conv_start_c;
  logic [COORD_W-1:0]    conv_bin_c;
  logic                  conv_done;
  logic [FULL_W-1:0]     conv_bcd;

  logic                  ld_new_c;
  logic                  ld_pend_c;
  logic                  cap_x_c;
  logic                  publish_c;
  logic                  pend_wr_c;
  logic                  pend_clr_c;
  logic                  drop_inc_c;

  logic                  pend_full;
  logic [2*COORD_W-1:0]  pend_data;
  logic [COORD_W-1:0]    y_lat;
  logic [OUT_W-1:0]      x_fld;
  logic                  x_ovf;
  logic [OUT_W:0]        fit_c;

  logic [2*OUT_W-1:0]    bcd_data;
  logic                  bcd_valid;
  logic                  busy;
  logic                  ovf_x;
  logic                  ovf_y;
  logic [DROP_CNT_W-1:0] drop_cnt;

  logic [COORD_W-1:0]    in_x;
  logic [COORD_W-1:0]    in_y;
  logic [COORD_W-1:0]    pend_x;
  logic [COORD_W-1:0]    pend_y;

  assign in_x   = bus.coord_data[2*COORD_W-1:COORD_W];
  assign in_y   = bus.coord_data[COORD_W-1:0];
  assign pend_x = pend_data[2*COORD_W-1:COORD_W];
  assign pend_y = pend_data[COORD_W-1:0];

  // Trim converter output to the display width: {overflow, field}.
  function automatic logic [OUT_W:0] fit(input logic [FULL_W-1:0] v);
    logic [EXT_W-1:0] ext;
    logic             ovf;
    ext = EXT_W'(v);
    ovf = (ext >> OUT_W) != '0;
    return {ovf, (ovf && SAT_EN) ? {BCD_DIGITS{4'h9}} : ext[OUT_W-1:0]};
  endfunction

  assign fit_c = fit(conv_bcd);

  bcd_dabble_serial #(
    .COORD_W     (COORD_W),
    .FULL_DIGITS (FULL_D)
  ) u_dabble (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .start   (conv_start_c),
    .bin     (conv_bin_c),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-edge control decisions.
  always_comb begin
    state_nxt    = state;
    conv_start_c = 1'b0;
    conv_bin_c   = '0;
    ld_new_c     = 1'b0;
    ld_pend_c    = 1'b0;
    cap_x_c      = 1'b0;
    publish_c    = 1'b0;
    pend_wr_c    = 1'b0;
    pend_clr_c   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.coord_valid) begin
          ld_new_c     = 1'b1;
          conv_start_c = 1'b1;
          conv_bin_c   = in_x;
          state_nxt    = CONV_X;
        end
      end
      CONV_X: begin
        pend_wr_c = bus.coord_valid;
        if (conv_done) begin
          cap_x_c      = 1'b1;
          conv_start_c = 1'b1;
          conv_bin_c   = y_lat;
          state_nxt    = CONV_Y;
        end
      end
      CONV_Y: begin
        if (conv_done) begin
          publish_c  = 1'b1;
          pend_clr_c = 1'b1;
          if (bus.coord_valid) begin
            ld_new_c     = 1'b1;
            conv_start_c = 1'b1;
            conv_bin_c   = in_x;
            state_nxt    = CONV_X;
          end else if (pend_full) begin
            ld_pend_c    = 1'b1;
            conv_start_c = 1'b1;
            conv_bin_c   = pend_x;
            state_nxt    = CONV_X;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          pend_wr_c = bus.coord_valid;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A full pending slot is lost when overwritten or when a fresh sample wins the publish edge.
  assign drop_inc_c = pend_full && (pend_wr_c || ld_new_c);

  // Sample latches, pending slot and the X intermediate result.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      y_lat     <= '0;
      pend_full <= 1'b0;
      pend_data <= '0;
      x_fld     <= '0;
      x_ovf     <= 1'b0;
    end else begin
      if (ld_new_c) begin
        y_lat <= in_y;
      end else if (ld_pend_c) begin
        y_lat <= pend_y;
      end
      if (pend_wr_c) begin
        pend_full <= 1'b1;
        pend_data <= bus.coord_data;
      end else if (pend_clr_c) begin
        pend_full <= 1'b0;
      end
      if (cap_x_c) begin
        x_fld <= fit_c[OUT_W-1:0];
        x_ovf <= fit_c[OUT_W];
      end
    end
  end

  // Published outputs, busy flag and drop counter.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bcd_data  <= '0;
      bcd_valid <= 1'b0;
      busy      <= 1'b0;
      ovf_x     <= 1'b0;
      ovf_y     <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      bcd_valid <= publish_c;
      busy      <= (state_nxt != IDLE);
      if (publish_c) begin
        bcd_data <= {x_fld, fit_c[OUT_W-1:0]};
        ovf_x    <= x_ovf;
        ovf_y    <= fit_c[OUT_W];
      end
      if (drop_inc_c && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
    end
  end

  assign bus.bcd_data  = bcd_data;
  assign bus.bcd_valid = bcd_valid;
  assign bus.busy      = busy;
  assign bus.ovf_x     = ovf_x;
  assign bus.ovf_y     = ovf_y;
  assign bus.drop_cnt  = drop_cnt;

endmodule

// File: tb/tb_coord_bcd_sched.sv
// Scoreboard bench for coord_bcd_sched: saturating and wrapping instances share stimulus.
module tb_coord_bcd_sched;

  localparam int unsigned CW  = 16;
  localparam int unsigned BD  = 4;
  localparam int          LAT = 2 * (CW + 1);

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  logic          cv = 1'b0;
  logic [31:0]   cd = '0;

  coord_bcd_sched_if #(.COORD_W(CW), .BCD_DIGITS(BD)) if_s ();
  coord_bcd_sched_if #(.COORD_W(CW), .BCD_DIGITS(BD)) if_w ();

  assign if_s.coord_valid = cv;
  assign if_s.coord_data  = cd;
  assign if_w.coord_valid = cv;
  assign if_w.coord_data  = cd;

  coord_bcd_sched #(.COORD_W(CW), .BCD_DIGITS(BD), .SAT_EN(1'b1)) u_sat (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (if_s)
  );

  coord_bcd_sched #(.COORD_W(CW), .BCD_DIGITS(BD), .SAT_EN(1'b0)) u_wrap (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (if_w)
  );

  typedef struct {
    logic [31:0] bcd_s;
    logic [31:0] bcd_w;
    logic        ox;
    logic        oy;
    int          drop;
    int          pub_cyc;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int tcount = 0;

  // Transaction-level model: each accepted sample occupies the converter for LAT edges.
  bit          m_act  = 1'b0;
  bit          m_pend = 1'b0;
  int          m_rem  = 0;
  logic [31:0] m_cur  = '0;
  logic [31:0] m_pdat = '0;
  int          m_drop = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, tcount, act, want);
    end
  endtask

  // Decimal digits of a coordinate, clamped or wrapped to BD digits.
  function automatic logic [15:0] ref_field(input int v, input bit sat);
    int lim;
    int val;
    logic [15:0] r;
    lim = 1;
    for (int i = 0; i < int'(BD); i++) lim = lim * 10;
    val = v;
    if (v >= lim) val = sat ? (lim - 1) : (v % lim);
    r = '0;
    for (int i = 0; i < int'(BD); i++) begin
      r[4*i +: 4] = 4'(val % 10);
      val = val / 10;
    end
    return r;
  endfunction

  function automatic bit over(input int v);
    return v > 9999;
  endfunction

  task automatic bump_drop();
    if (m_drop < 255) m_drop++;
  endtask

  task automatic model_edge(input bit v, input logic [31:0] d);
    exp_t e;
    int x;
    int y;
    if (m_act) begin
      m_rem--;
      if (m_rem == 0) begin
        x = int'(m_cur[31:16]);
        y = int'(m_cur[15:0]);
        e.bcd_s = {ref_field(x, 1'b1), ref_field(y, 1'b1)};
        e.bcd_w = {ref_field(x, 1'b0), ref_field(y, 1'b0)};
        e.ox = over(x);
        e.oy = over(y);
        if (v) begin
          if (m_pend) bump_drop();
          m_pend = 1'b0;
          m_cur  = d;
          m_rem  = LAT;
        end else if (m_pend) begin
          m_cur  = m_pdat;
          m_pend = 1'b0;
          m_rem  = LAT;
        end else begin
          m_act = 1'b0;
        end
        e.drop    = m_drop;
        e.pub_cyc = tcount;
        q.push_back(e);
      end else if (v) begin
        if (m_pend) bump_drop();
        m_pend = 1'b1;
        m_pdat = d;
      end
    end else if (v) begin
      m_act = 1'b1;
      m_cur = d;
      m_rem = LAT;
    end
  endtask

  task automatic tick(input bit v, input logic [31:0] d);
    cv = v;
    cd = d;
    @(posedge sys_clk);
    tcount++;
    model_edge(v, d);
    #1;
    chk("busy", {if_s.busy, if_w.busy}, {m_act, m_act});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0);
  endtask

  task automatic send(input int x, input int y);
    tick(1'b1, {16'(x), 16'(y)});
  endtask

  task automatic check_zero(input string name);
    chk({name, "_bcd"}, {if_s.bcd_data, if_w.bcd_data}, 64'd0);
    chk({name, "_flags"}, {if_s.bcd_valid, if_s.busy, if_s.ovf_x, if_s.ovf_y,
                           if_w.bcd_valid, if_w.busy, if_w.ovf_x, if_w.ovf_y}, 64'd0);
    chk({name, "_drop"}, {if_s.drop_cnt, if_w.drop_cnt}, 64'd0);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    cv = 1'b0;
    #1;
    check_zero("rst_async");
    m_act = 1'b0; m_pend = 1'b0; m_rem = 0; m_drop = 0;
    q.delete();
    repeat (2) begin
      @(posedge sys_clk);
      tcount++;
    end
    #1;
    sys_rst = 1'b0;
  endtask

  // Monitor: every published word is checked against the oldest expected result.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (if_s.bcd_valid !== if_w.bcd_valid) begin
        chk("valid_pair", {63'd0, if_w.bcd_valid}, {63'd0, if_s.bcd_valid});
      end
      if (if_s.bcd_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("bcd_sat",  {32'd0, if_s.bcd_data}, {32'd0, e.bcd_s});
          chk("bcd_wrap", {32'd0, if_w.bcd_data}, {32'd0, e.bcd_w});
          chk("ovf", {if_s.ovf_x, if_s.ovf_y, if_w.ovf_x, if_w.ovf_y},
                     {e.ox, e.oy, e.ox, e.oy});
          chk("drop_cnt", {if_s.drop_cnt, if_w.drop_cnt}, {8'(e.drop), 8'(e.drop)});
          chk("latency", 64'(tcount), 64'(e.pub_cyc));
        end
      end
    end
  end

  initial begin
    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check_zero("reset");
    sys_rst = 1'b0;
    idle(3);

    // Single sample and digit boundaries.
    send(123, 456);     idle(LAT + 4);
    send(0, 9999);      idle(LAT + 4);
    send(12345, 65535); idle(LAT + 4);
    send(10000, 9998);  idle(LAT + 4);

    // Back-to-back A/B/C: B is overwritten by C.
    send(1111, 2222); idle(4);
    send(3333, 4444); idle(4);
    send(5555, 6666); idle(2 * LAT + 4);

    // New sample exactly on the publish edge, pending empty then pending full.
    send(7, 8);    idle(LAT - 1); send(77, 88);   idle(LAT + 4);
    send(9, 10);   idle(4); send(99, 100); idle(LAT - 6); send(999, 1000); idle(LAT + 4);

    // Reset in the middle of a conversion, then a clean restart.
    send(4321, 8765); idle(19);
    do_reset();
    idle(3);
    send(2468, 1357); idle(LAT + 4);

    // Random traffic with sparse strobes.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) send($urandom_range(0, 12000), $urandom_range(0, 12000));
        else tick(1'b1, $urandom);
      end else begin
        tick(1'b0, '0);
      end
    end
    idle(2 * LAT + 4);

    // Continuous strobes push the drop counter into saturation.
    for (int i = 0; i < 320; i++) tick(1'b1, $urandom);
    idle(2 * LAT + 4);
    chk("drop_sat", {if_s.drop_cnt, if_w.drop_cnt}, {8'd255, 8'd255});
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
